// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL gear sequencer: state and gear encodings,
// ADPLL register select codes, and the saturating counter helper.
// No logic of its own; imported by adpll_pgm_writer and adpll_gear_seq.
package adpll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PROG  = 3'd2,
        ST_ACQ   = 3'd3,
        ST_TRACK = 3'd4
    } state_t;

    typedef enum logic {
        GEAR_ACQ = 1'b0,
        GEAR_TRK = 1'b1
    } gear_t;

    localparam logic [2:0] PSEL_KP = 3'd0;
    localparam logic [2:0] PSEL_KI = 3'd1;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/adpll_pgm_writer.sv
// Purpose: one ADPLL register write: SETUP (data valid, pgm=0), PGM_HOLD strobe cycles, HOLD (data stable, pgm=0).
// Latency: outputs registered; SETUP appears the cycle after start, done is high during HOLD; a start seen in HOLD chains straight into the next SETUP.
// Backpressure: none; abort (or rst) returns to idle next cycle with pgm, param_sel and pgm_value cleared.
// Ports: clk, rst (sync, active-high), start/sel/value (write request), abort,
//        pgm/param_sel/pgm_value (registered ADPLL bus), done (write completing this cycle).
module adpll_pgm_writer
    import adpll_pkg::*;
#(
    parameter int PGM_HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] sel,
    input  logic [4:0] value,
    output logic       pgm,
    output logic [2:0] param_sel,
    output logic [4:0] pgm_value,
    output logic       done
);

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_SETUP  = 2'd1,
        W_STROBE = 2'd2,
        W_HOLD   = 2'd3
    } wstate_t;

    localparam logic [7:0] HOLD_LAST = 8'(PGM_HOLD - 1);

    wstate_t    wst, wst_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;

    always_comb begin
        wst_nxt      = wst;
        hold_cnt_nxt = hold_cnt;
        case (wst)
            W_IDLE:   if (start) wst_nxt = W_SETUP;
            W_SETUP: begin
                wst_nxt      = W_STROBE;
                hold_cnt_nxt = 8'd0;
            end
            W_STROBE: begin
                if (hold_cnt == HOLD_LAST) wst_nxt = W_HOLD;
                else                       hold_cnt_nxt = hold_cnt + 8'd1;
            end
            W_HOLD:   wst_nxt = start ? W_SETUP : W_IDLE;
            default:  wst_nxt = W_IDLE;
        endcase
        if (abort) wst_nxt = W_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wst       <= W_IDLE;
            hold_cnt  <= 8'd0;
            pgm       <= 1'b0;
            param_sel <= 3'd0;
            pgm_value <= 5'd0;
        end else begin
            wst      <= wst_nxt;
            hold_cnt <= hold_cnt_nxt;
            pgm      <= (wst_nxt == W_STROBE);
            // Data is captured only on SETUP entry, so it stays stable through strobe and HOLD.
            if (wst_nxt == W_SETUP) begin
                param_sel <= sel;
                pgm_value <= value;
            end else if (wst_nxt == W_IDLE) begin
                param_sel <= 3'd0;
                pgm_value <= 5'd0;
            end
        end
    end

    assign done = (wst == W_HOLD);

endmodule

// File: rtl/adpll_gear_seq.sv
// Purpose: ADPLL gear sequencer: clear, program acquisition gains, watch phase error for lock, reprogram tracking gains, detect loss of lock.
// Latency: all outputs registered; state/outputs follow inputs by one cycle; each PROG is 2*(PGM_HOLD+2) cycles.
// Backpressure: none; dout sampled every cycle, en=0 returns to IDLE next cycle aborting any write.
// Ports: clk, rst (sync, active-high), en, dout/sign (phase error), acq_/trk_ kp/ki gains;
//        clr, pgm, param_sel, pgm_value (ADPLL control), locked, busy, state (status).
module adpll_gear_seq
    import adpll_pkg::*;
#(
    parameter int CLR_CYCLES    = 4,
    parameter int PGM_HOLD      = 2,
    parameter int LOCK_THRESH   = 2,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 6,
    parameter int UNLOCK_COUNT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] dout,
    input  logic       sign,
    input  logic [4:0] acq_kp,
    input  logic [4:0] acq_ki,
    input  logic [4:0] trk_kp,
    input  logic [4:0] trk_ki,
    output logic       clr,
    output logic       pgm,
    output logic [2:0] param_sel,
    output logic [4:0] pgm_value,
    output logic       locked,
    output logic       busy,
    output logic [2:0] state
);

    localparam logic [7:0] CLR_LAST  = 8'(CLR_CYCLES - 1);
    localparam logic [7:0] LOCK_N    = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_N  = 8'(UNLOCK_COUNT);
    localparam logic [4:0] LOCK_TH   = 5'(LOCK_THRESH);
    localparam logic [4:0] UNLOCK_TH = 5'(UNLOCK_THRESH);

    state_t     st, st_nxt;
    gear_t      gear, prog_gear;
    logic [7:0] cnt, cnt_nxt;
    logic [4:0] sh_kp, sh_ki;
    logic       wr_idx;          // 0: kp write in flight, 1: ki write in flight
    logic       prog_entry;
    logic       wr_start, wr_abort, wr_done;
    logic [2:0] wr_sel;
    logic [4:0] wr_val;
    logic       clr_d, locked_d, busy_d;

    // Magnitude only; the sign of the phase error plays no part in thresholding.
    logic       sign_unused;
    assign sign_unused = sign;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= ST_IDLE;
            cnt    <= 8'd0;
            gear   <= GEAR_ACQ;
            sh_kp  <= 5'd0;
            sh_ki  <= 5'd0;
            wr_idx <= 1'b0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
            if (prog_entry) begin
                gear   <= prog_gear;
                sh_kp  <= (prog_gear == GEAR_TRK) ? trk_kp : acq_kp;
                sh_ki  <= (prog_gear == GEAR_TRK) ? trk_ki : acq_ki;
                wr_idx <= 1'b0;
            end else if (wr_start) begin
                wr_idx <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        wr_start  = 1'b0;
        wr_sel    = PSEL_KP;
        wr_val    = 5'd0;
        prog_gear = (st == ST_ACQ) ? GEAR_TRK : GEAR_ACQ;
        case (st)
            ST_IDLE:  st_nxt = ST_CLEAR;
            ST_CLEAR: begin
                if (cnt == CLR_LAST) st_nxt = ST_PROG;
                else                 cnt_nxt = sat_inc(cnt);
            end
            ST_PROG: begin
                if (wr_done) begin
                    if (!wr_idx) begin
                        wr_start = 1'b1;
                        wr_sel   = PSEL_KI;
                        wr_val   = sh_ki;
                    end else begin
                        st_nxt = (gear == GEAR_TRK) ? ST_TRACK : ST_ACQ;
                    end
                end
            end
            ST_ACQ: begin
                if (dout <= LOCK_TH) begin
                    cnt_nxt = sat_inc(cnt);
                    if (cnt_nxt >= LOCK_N) st_nxt = ST_PROG;
                end else begin
                    cnt_nxt = 8'd0;
                end
            end
            ST_TRACK: begin
                if (dout >= UNLOCK_TH) begin
                    cnt_nxt = sat_inc(cnt);
                    if (cnt_nxt >= UNLOCK_N) st_nxt = ST_CLEAR;
                end else begin
                    cnt_nxt = 8'd0;
                end
            end
            default:  st_nxt = ST_IDLE;
        endcase
        if (!en) st_nxt = ST_IDLE;
        // The kp write starts on the same edge PROG is entered, straight from the gain
        // inputs, so its SETUP lines up with the first PROG cycle.
        prog_entry = (st_nxt == ST_PROG) && (st != ST_PROG);
        if (prog_entry) begin
            wr_start = 1'b1;
            wr_sel   = PSEL_KP;
            wr_val   = (prog_gear == GEAR_TRK) ? trk_kp : acq_kp;
        end
        if (st_nxt != st) cnt_nxt = 8'd0;
    end

    // Leaving PROG for any reason kills the write without a HOLD cycle.
    assign wr_abort = (st_nxt != ST_PROG);

    adpll_pgm_writer #(
        .PGM_HOLD (PGM_HOLD)
    ) u_writer (
        .clk       (clk),
        .rst       (rst),
        .start     (wr_start),
        .abort     (wr_abort),
        .sel       (wr_sel),
        .value     (wr_val),
        .pgm       (pgm),
        .param_sel (param_sel),
        .pgm_value (pgm_value),
        .done      (wr_done)
    );

    // Output decode from the upcoming state
    always_comb begin
        clr_d    = (st_nxt == ST_CLEAR);
        locked_d = (st_nxt == ST_TRACK);
        busy_d   = (st_nxt == ST_CLEAR) || (st_nxt == ST_PROG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr    <= 1'b0;
            locked <= 1'b0;
            busy   <= 1'b0;
        end else begin
            clr    <= clr_d;
            locked <= locked_d;
            busy   <= busy_d;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_adpll_gear_seq.sv
// Directed bench for adpll_gear_seq: each stimulus cycle queues the hand-derived
// output vector expected after the next clock edge; a monitor pops and compares
// every cycle, one cycle after the edge.
module tb_adpll_gear_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [4:0] dout = 5'd0;
    logic       sign = 1'b0;
    logic [4:0] acq_kp = 5'd5;
    logic [4:0] acq_ki = 5'd7;
    logic [4:0] trk_kp = 5'd11;
    logic [4:0] trk_ki = 5'd13;
    logic       clr, pgm, locked, busy;
    logic [2:0] param_sel, state;
    logic [4:0] pgm_value;

    localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_PROG = 3'd2, S_ACQ = 3'd3, S_TRACK = 3'd4;

    typedef struct {
        logic [14:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    adpll_gear_seq dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dout      (dout),
        .sign      (sign),
        .acq_kp    (acq_kp),
        .acq_ki    (acq_ki),
        .trk_kp    (trk_kp),
        .trk_ki    (trk_ki),
        .clr       (clr),
        .pgm       (pgm),
        .param_sel (param_sel),
        .pgm_value (pgm_value),
        .locked    (locked),
        .busy      (busy),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic e, input logic [4:0] d,
                       input logic [2:0] st, input logic c, input logic p,
                       input logic [2:0] sel, input logic [4:0] val,
                       input logic lk, input string nm);
        exp_t x;
        logic bz;
        rst  = r;
        en   = e;
        dout = d;
        sign = d[0];
        bz   = (st == S_CLEAR) || (st == S_PROG);
        x.v    = {st, c, p, sel, val, lk, bz};
        x.name = nm;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic t_clear(input logic [4:0] d);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, d, S_CLEAR, 1'b1, 1'b0, 3'd0, 5'd0, 1'b0, "clear");
    endtask

    task automatic t_write(input logic [2:0] sel, input logic [4:0] val, input logic [4:0] d, input logic swap);
        cyc(1'b0, 1'b1, d, S_PROG, 1'b0, 1'b0, sel, val, 1'b0, "wr_setup");
        if (swap) acq_kp = 5'd9;
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, d, S_PROG, 1'b0, 1'b1, sel, val, 1'b0, "wr_strobe");
        cyc(1'b0, 1'b1, d, S_PROG, 1'b0, 1'b0, sel, val, 1'b0, "wr_hold");
    endtask

    task automatic t_prog(input logic [4:0] kp, input logic [4:0] ki, input logic [4:0] d);
        t_write(3'd0, kp, d, 1'b0);
        t_write(3'd1, ki, d, 1'b0);
    endtask

    task automatic t_stay(input int n, input logic [2:0] st, input logic [4:0] d, input logic lk, input string nm);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, d, st, 1'b0, 1'b0, 3'd0, 5'd0, lk, nm);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t        x;
        logic [14:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x   = exp_q.pop_front();
                act = {state, clr, pgm, param_sel, pgm_value, locked, busy};
                checks++;
                if (act !== x.v) begin
                    errors++;
                    $display("FAIL %s @%0t: got st=%0d clr=%b pgm=%b sel=%0d val=%0d lk=%b busy=%b, want st=%0d clr=%b pgm=%b sel=%0d val=%0d lk=%b busy=%b",
                             x.name, $time, act[14:12], act[11], act[10], act[9:7], act[6:2], act[1], act[0],
                             x.v[14:12], x.v[11], x.v[10], x.v[9:7], x.v[6:2], x.v[1], x.v[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset overrides en; en held high as rst deasserts.
        cyc(1'b1, 1'b0, 5'd0, S_IDLE, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, "reset");
        cyc(1'b1, 1'b1, 5'd0, S_IDLE, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, "reset_en");

        // Full bring-up with dout=0: clear, acq gains, 16 ACQ cycles, trk gains, TRACK.
        t_clear(5'd0);
        t_prog(5'd5, 5'd7, 5'd0);
        t_stay(16, S_ACQ, 5'd0, 1'b0, "acq");
        t_prog(5'd11, 5'd13, 5'd0);
        cyc(1'b0, 1'b1, 5'd0, S_TRACK, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1, "track_entry");

        // Loss of lock: 6,6,6 then 5 restarts; four 7s drop lock into CLEAR.
        t_stay(3, S_TRACK, 5'd6, 1'b1, "track_unlk6");
        t_stay(1, S_TRACK, 5'd5, 1'b1, "track_unlk5");
        t_stay(3, S_TRACK, 5'd7, 1'b1, "track_unlk7");
        t_clear(5'd7);
        t_prog(5'd5, 5'd7, 5'd7);

        // Lock counter restart: 15x2, one 3, then lock on the 16th following 1.
        t_stay(1, S_ACQ, 5'd1, 1'b0, "acq_entry");
        t_stay(15, S_ACQ, 5'd2, 1'b0, "acq_d2");
        t_stay(1, S_ACQ, 5'd3, 1'b0, "acq_d3");
        t_stay(15, S_ACQ, 5'd1, 1'b0, "acq_d1");
        t_prog(5'd11, 5'd13, 5'd1);
        cyc(1'b0, 1'b1, 5'd0, S_TRACK, 1'b0, 1'b0, 3'd0, 5'd0, 1'b1, "track_entry2");
        t_stay(2, S_TRACK, 5'd0, 1'b1, "track_hold");

        // One-cycle reset in TRACK, then re-sequence; acq_kp changes during kp SETUP.
        cyc(1'b1, 1'b1, 5'd0, S_IDLE, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, "rst_in_track");
        t_clear(5'd0);
        t_write(3'd0, 5'd5, 5'd0, 1'b1);

        // en drops during the ki strobe: straight to IDLE, no HOLD.
        cyc(1'b0, 1'b1, 5'd0, S_PROG, 1'b0, 1'b0, 3'd1, 5'd7, 1'b0, "ki_setup");
        cyc(1'b0, 1'b1, 5'd0, S_PROG, 1'b0, 1'b1, 3'd1, 5'd7, 1'b0, "ki_strobe");
        cyc(1'b0, 1'b0, 5'd0, S_IDLE, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, "en_abort");
        cyc(1'b0, 1'b0, 5'd0, S_IDLE, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, "idle_en0");

        // Restart picks up the new acq_kp; out-of-lock dout keeps ACQ; en=0 from ACQ.
        t_clear(5'd0);
        t_prog(5'd9, 5'd7, 5'd0);
        t_stay(3, S_ACQ, 5'd9, 1'b0, "acq_noisy");
        cyc(1'b0, 1'b0, 5'd0, S_IDLE, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, "acq_en0");

        // Reset during the kp strobe: pgm drops, then CLEAR again.
        t_clear(5'd0);
        cyc(1'b0, 1'b1, 5'd0, S_PROG, 1'b0, 1'b0, 3'd0, 5'd9, 1'b0, "kp_setup");
        cyc(1'b0, 1'b1, 5'd0, S_PROG, 1'b0, 1'b1, 3'd0, 5'd9, 1'b0, "kp_strobe");
        cyc(1'b1, 1'b1, 5'd0, S_IDLE, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, "rst_mid_write");
        cyc(1'b0, 1'b1, 5'd0, S_CLEAR, 1'b1, 1'b0, 3'd0, 5'd0, 1'b0, "restart_clear");

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adpll_gear_seq.md
ADPLL_GEAR_SEQ -- requirements
Module: adpll_gear_seq

Interface
REQ-001 Parameter CLR_CYCLES, default 4: cycles clr is held high per clear.
REQ-002 Parameter PGM_HOLD, default 2: cycles pgm is held high per register write.
REQ-003 Parameter LOCK_THRESH, default 2: max |phase error| counted as in-lock.
REQ-004 Parameter LOCK_COUNT, default 16: consecutive in-lock cycles to declare lock.
REQ-005 Parameter UNLOCK_THRESH, default 6: min |phase error| counted as out-of-lock.
REQ-006 Parameter UNLOCK_COUNT, default 4: consecutive out-of-lock cycles to declare loss of lock.
REQ-007 Ports, one clock; reset is synchronous and active-high:
  clk  in  1  system clock
  rst  in  1  synchronous active-high reset
  en  in  1  sequencer enable
  dout  in  5  ADPLL phase-error magnitude
  sign  in  1  ADPLL phase-error sign (not used for magnitude)
  acq_kp, acq_ki  in  5 each  acquisition-gear gains
  trk_kp, trk_ki  in  5 each  tracking-gear gains
  clr  out  1  ADPLL clear
  pgm  out  1  ADPLL program strobe
  param_sel  out  3  ADPLL register select
  pgm_value  out  5  ADPLL program data
  locked  out  1  lock status
  busy  out  1  high in CLEAR or PROG
  state  out  3  current state encoding

Function
REQ-008 States: IDLE=0, CLEAR=1, PROG=2, ACQ=3, TRACK=4; all registered outputs.
REQ-009 IDLE: en=1 -> CLEAR next cycle; all outputs 0.
REQ-010 CLEAR: clr=1 exactly CLR_CYCLES cycles, then PROG with gear=ACQ.
REQ-011 PROG: on entry, gear gains copied to shadow registers; later input changes ignored until next PROG.
REQ-012 PROG performs two writes in order: kp (param_sel=3'd0), then ki (param_sel=3'd1).
REQ-013 Each write: 1 SETUP cycle (param_sel/pgm_value valid, pgm=0), PGM_HOLD cycles pgm=1, 1 HOLD cycle (values stable, pgm=0); total 2*(PGM_HOLD+2) cycles.
REQ-014 After last HOLD: gear ACQ -> ACQ state; gear TRK -> TRACK state, locked=1 same cycle as TRACK entry.
REQ-015 param_sel and pgm_value SHALL be 0 outside PROG.
REQ-016 ACQ: lock counter increments when dout<=LOCK_THRESH, clears to 0 otherwise; reaching LOCK_COUNT -> PROG with gear=TRK, counter cleared.
REQ-017 TRACK: unlock counter increments when dout>=UNLOCK_THRESH, clears otherwise; reaching UNLOCK_COUNT -> locked=0, CLEAR, counter cleared.
REQ-018 Counters 8-bit, saturating at 255, cleared on every state change.
REQ-019 en=0 in any state -> IDLE next cycle; clr, pgm, locked drop that cycle; in-progress write aborted without HOLD.
REQ-020 en=1 held in IDLE on the same cycle rst deasserts -> CLEAR on following cycle.
REQ-021 dout sampled every cycle with no valid qualifier; sign ignored for thresholding.

Reset
REQ-022 rst=1 at any clock edge: state=IDLE, all outputs 0, counters and shadow gains 0; overrides en.
REQ-023 rst mid-write: pgm=0 next cycle; no partial write completion.

Structure
REQ-024 Shared package adpll_pkg: state encoding enum, param_sel codes PSEL_KP=3'd0, PSEL_KI=3'd1, gear enum.
REQ-025 One sub-module adpll_pgm_writer: single write transaction (start, sel, value -> SETUP/STROBE/HOLD, done pulse, abort input).
REQ-026 No combinational path from inputs to outputs.

Verification
REQ-027 Reset, en=1, dout=0 constant -> clr high cycles 1-4, writes (0,acq_kp),(1,acq_ki) each with pgm high 2 cycles, ACQ, 16 cycles later trk writes, TRACK with locked=1.
REQ-028 In ACQ, dout=2 for 15 cycles, dout=3 once, then dout=1 -> lock counter restarts; lock declared 16 cycles after the dout=3 cycle.
REQ-029 In TRACK, dout=6 for 3 cycles, dout=5, dout=7 for 4 cycles -> locked falls after the 4th dout=7 cycle, CLEAR entered with clr=1.
REQ-030 en=0 during pgm=1 of ki write -> next cycle pgm=0, state=IDLE, busy=0; en=1 restarts from CLEAR.
REQ-031 Change acq_kp from 5 to 9 during SETUP of kp write -> pgm_value stays at shadowed 5.
REQ-032 rst=1 for one cycle in TRACK -> locked=0, state=IDLE next cycle; with en=1 re-sequences from CLEAR.
